// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the elastic pipeline-stage register.
//   OCC_W : width of the occupancy encoding (0, 1 or 2 held items)
//   occ_t : occupancy state of a stage, whose encoding equals its item count
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int OCC_W = 2;

    // The encoding matches the number of held items, so the state register
    // can drive the occupancy output directly.
    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance statistics. It stops at all-ones
// rather than wrapping, so a long stall can never read as a short one.
// Ports:
//   clk   in  1 : clock, rising edge
//   rst   in  1 : synchronous active-high reset, clears the count
//   inc   in  1 : count this cycle
//   count out W : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Advance only while below all-ones; once saturated the value is held.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic register between two pipeline stages with a valid/ready handshake,
// an optional skid entry for a registered s_ready, a flush that spares a
// protected (control-transfer) head item, occupancy and a stall counter.
// Parameters:
//   PAYLOAD_W   : payload width
//   SKID        : 1 = two entries, registered s_ready; 0 = one entry,
//                 combinational s_ready
//   STALL_CNT_W : stall counter width
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   s_valid/s_ready/s_data/s_protect : upstream handshake and item
//   flush                 : kill held and arriving wrong-path items
//   m_valid/m_ready/m_data/m_protect : downstream handshake and head item
//   occupancy             : number of held items
//   stall_cnt             : saturating count of m_valid && !m_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W   = 128,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PAYLOAD_W-1:0]   s_data,
    input  logic                   s_protect,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PAYLOAD_W-1:0]   m_data,
    output logic                   m_protect,
    output logic [OCC_W-1:0]       occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Each entry is {protect, payload}.
    localparam int ENTRY_W = PAYLOAD_W + 1;

    occ_t               occ_q;
    occ_t               occ_d;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] head_d;
    logic [ENTRY_W-1:0] skid_q;
    logic [ENTRY_W-1:0] skid_d;
    logic [ENTRY_W-1:0] inEntry;
    logic               pushEn;
    logic               popEn;

    assign inEntry = {s_protect, s_data};
    assign m_valid = (occ_q != EMPTY);

    // Head is kept zero when empty, the gating makes the bubble explicit.
    assign m_data    = m_valid ? head_q[PAYLOAD_W-1:0] : '0;
    assign m_protect = m_valid & head_q[PAYLOAD_W];
    assign occupancy = occ_q;

    // Flush overrides any push, so a wrong-path item never enters.
    assign pushEn = s_valid && s_ready && !flush;
    assign popEn  = m_valid && m_ready;

    // Next-state and entry-movement logic. Vacated entries are zeroed so the
    // bubble seen downstream is an all-zero control word.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            skid_d = '0;
            if (m_valid && m_protect && !popEn) begin
                occ_d = ONE;
            end else begin
                occ_d  = EMPTY;
                head_d = '0;
            end
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (pushEn) begin
                        occ_d  = ONE;
                        head_d = inEntry;
                    end
                end
                ONE: begin
                    if (pushEn && popEn) begin
                        head_d = inEntry;
                    end else if (pushEn) begin
                        occ_d  = TWO;
                        skid_d = inEntry;
                    end else if (popEn) begin
                        occ_d  = EMPTY;
                        head_d = '0;
                    end
                end
                TWO: begin
                    if (popEn) begin
                        occ_d  = ONE;
                        head_d = skid_q;
                        skid_d = '0;
                    end
                end
                default: begin
                    occ_d  = EMPTY;
                    head_d = '0;
                    skid_d = '0;
                end
            endcase
        end
    end

    // State and head entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= EMPTY;
            head_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    generate
        if (SKID != 0) begin : gSkid
            logic sReady_q;

            // s_ready is looked up from the next state so it never depends
            // combinationally on m_ready; the skid entry absorbs the one item
            // that may arrive after m_ready drops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_q   <= '0;
                    sReady_q <= 1'b1;
                end else begin
                    skid_q   <= skid_d;
                    sReady_q <= (occ_d != TWO);
                end
            end

            assign s_ready = sReady_q;
        end else begin : gNoSkid
            logic unusedSkid;

            // With a single entry the stage can only accept when the head
            // is empty or leaving this cycle, so TWO is never reached.
            assign skid_q     = '0;
            assign unusedSkid = ^skid_d;
            assign s_ready    = !m_valid || m_ready;
        end
    endgenerate

    sat_counter #(
        .W(STALL_CNT_W)
    ) uStallCnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (m_valid && !m_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance, a table of
// directed vectors, hand-written corner sequences and a random run against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int PW   = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam int NVEC = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          sValid1, sReady1, sProt1, flush1, mValid1, mReady1, mProt1;
    logic [PW-1:0] sData1, mData1;
    logic [1:0]    occ1;
    logic [CW-1:0] stall1;

    logic          sValid0, sReady0, sProt0, flush0, mValid0, mReady0, mProt0;
    logic [PW-1:0] sData0, mData0;
    logic [1:0]    occ0;
    logic [CW-1:0] stall0;

    pipe_stage_elastic #(.PAYLOAD_W(PW), .SKID(1), .STALL_CNT_W(CW)) dutSkid (
        .clk(clk), .rst(rst),
        .s_valid(sValid1), .s_ready(sReady1), .s_data(sData1), .s_protect(sProt1),
        .flush(flush1),
        .m_valid(mValid1), .m_ready(mReady1), .m_data(mData1), .m_protect(mProt1),
        .occupancy(occ1), .stall_cnt(stall1)
    );

    pipe_stage_elastic #(.PAYLOAD_W(PW), .SKID(0), .STALL_CNT_W(CW)) dutNoSkid (
        .clk(clk), .rst(rst),
        .s_valid(sValid0), .s_ready(sReady0), .s_data(sData0), .s_protect(sProt0),
        .flush(flush0),
        .m_valid(mValid0), .m_ready(mReady0), .m_data(mData0), .m_protect(mProt0),
        .occupancy(occ0), .stall_cnt(stall0)
    );

    // Selects which instance is being driven and observed.
    logic          selOne;
    logic          curSReady, curMValid, curMProt;
    logic [PW-1:0] curMData;
    logic [1:0]    curOcc;
    logic [CW-1:0] curStall;

    assign curSReady = selOne ? sReady1 : sReady0;
    assign curMValid = selOne ? mValid1 : mValid0;
    assign curMProt  = selOne ? mProt1  : mProt0;
    assign curMData  = selOne ? mData1  : mData0;
    assign curOcc    = selOne ? occ1    : occ0;
    assign curStall  = selOne ? stall1  : stall0;

    int vectorCount = 0;
    int missCount   = 0;

    typedef struct packed {
        logic          rst;
        logic          sValid;
        logic [PW-1:0] sData;
        logic          sProt;
        logic          flush;
        logic          mReady;
        logic          expMValid;
        logic [PW-1:0] expMData;
        logic          expMProt;
        logic [1:0]    expOcc;
        logic          expSReady;
        logic [CW-1:0] expStall;
    } vec_t;

    vec_t vecs [NVEC];

    // Reference model: a plain FIFO of {protect, data} plus a stall count.
    logic [PW:0] mq [$];
    int          stallM;
    bit          readyRegM;
    bit          modelSkid;

    task automatic applyStimulus(input logic r, input logic sv, input logic [PW-1:0] sd,
                                 input logic sp, input logic fl, input logic mr);
        rst = r;
        if (selOne) begin
            sValid1 = sv; sData1 = sd; sProt1 = sp; flush1 = fl; mReady1 = mr;
            sValid0 = 1'b0; sData0 = '0; sProt0 = 1'b0; flush0 = 1'b0; mReady0 = 1'b0;
        end else begin
            sValid0 = sv; sData0 = sd; sProt0 = sp; flush0 = fl; mReady0 = mr;
            sValid1 = 1'b0; sData1 = '0; sProt1 = 1'b0; flush1 = 1'b0; mReady1 = 1'b0;
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eMValid, input logic [PW-1:0] eMData,
                               input logic eMProt, input logic [1:0] eOcc,
                               input logic eSReady, input logic [CW-1:0] eStall);
        checkValue({tag, ".m_valid"},   32'(curMValid), 32'(eMValid));
        checkValue({tag, ".m_data"},    32'(curMData),  32'(eMData));
        checkValue({tag, ".m_protect"}, 32'(curMProt),  32'(eMProt));
        checkValue({tag, ".occupancy"}, 32'(curOcc),    32'(eOcc));
        checkValue({tag, ".s_ready"},   32'(curSReady), 32'(eSReady));
        checkValue({tag, ".stall_cnt"}, 32'(curStall),  32'(eStall));
    endtask

    task automatic modelReset();
        mq.delete();
        stallM    = 0;
        readyRegM = 1'b1;
    endtask

    task automatic modelStep(input logic r, input logic sv, input logic [PW-1:0] sd,
                             input logic sp, input logic fl, input logic mr);
        bit          mv, sr, pop, push, keep;
        logic [PW:0] head;
        if (r) begin
            modelReset();
            return;
        end
        mv   = (mq.size() > 0);
        sr   = modelSkid ? readyRegM : (!mv || mr);
        pop  = mv && mr;
        push = sv && sr && !fl;
        if (mv && !mr && stallM < CMAX) stallM++;
        if (fl) begin
            head = mv ? mq[0] : '0;
            keep = mv && head[PW] && !pop;
            mq.delete();
            if (keep) mq.push_back(head);
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({sp, sd});
        end
        readyRegM = (mq.size() != 2);
    endtask

    task automatic runRandom(input int cycles);
        logic          r, sv, sp, fl, mr, mv;
        logic [PW-1:0] sd;
        logic [PW:0]   head;
        for (int i = 0; i < cycles; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            sv = ($urandom_range(0, 3) != 0);
            sd = PW'($urandom);
            sp = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 15) == 0);
            mr = ($urandom_range(0, 2) != 0);
            applyStimulus(r, sv, sd, sp, fl, mr);
            #1;
            mv   = (mq.size() > 0);
            head = mv ? mq[0] : '0;
            checkOutput($sformatf("rand%0d[%0d]", modelSkid, i), mv, head[PW-1:0], head[PW],
                        2'(mq.size()), modelSkid ? readyRegM : (!mv || mr), CW'(stallM));
            modelStep(r, sv, sd, sp, fl, mr);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //          rst sv data      sp fl mr   mv data      mp occ  sr stall
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 2'd1, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 2'd1, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 2'd1, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 2'd1, 1'b1, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 2'd2, 1'b0, 4'd1};
        vecs[7]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 2'd2, 1'b0, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000B, 1'b0, 2'd1, 1'b1, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd2};
        vecs[10] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 2'd1, 1'b1, 4'd2};
        vecs[11] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 2'd2, 1'b0, 4'd3};
        vecs[12] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 2'd1, 1'b1, 4'd4};
        vecs[13] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 2'd1, 1'b1, 4'd5};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd5};
        vecs[15] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 2'd1, 1'b1, 4'd5};
        vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd6};
        vecs[17] = '{1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 2'd1, 1'b1, 4'd6};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd0};

        selOne = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Directed table on the skid build.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sValid, vecs[i].sData,
                          vecs[i].sProt, vecs[i].flush, vecs[i].mReady);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expMValid, vecs[i].expMData,
                        vecs[i].expMProt, vecs[i].expOcc, vecs[i].expSReady, vecs[i].expStall);
        end

        // Stall counter saturation, then reset in the middle of the stall.
        applyStimulus(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("satPush", 1'b1, 16'h0042, 1'b0, 2'd1, 1'b1, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            if (i == 14) checkValue("sat14.stall_cnt", 32'(curStall), 32'd14);
            if (i == 15) checkValue("sat15.stall_cnt", 32'(curStall), 32'd15);
        end
        checkOutput("sat20", 1'b1, 16'h0042, 1'b0, 2'd1, 1'b1, 4'd15);
        applyStimulus(1'b1, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("satReset", 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 4'd0);

        // Combinational s_ready of the single-entry build.
        selOne = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b0);
        #1;
        checkValue("noSkidEmpty.s_ready", 32'(curSReady), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 16'h0BBB, 1'b0, 1'b0, 1'b0);
        #1;
        checkValue("noSkidFull.s_ready", 32'(curSReady), 32'd0);
        @(posedge clk);
        #1;
        checkValue("noSkidHold.m_data", 32'(curMData), 32'h0AAA);
        checkValue("noSkidHold.occupancy", 32'(curOcc), 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0BBB, 1'b0, 1'b0, 1'b1);
        #1;
        checkValue("noSkidRelease.s_ready", 32'(curSReady), 32'd1);
        @(posedge clk);
        #1;
        checkValue("noSkidSwap.m_data", 32'(curMData), 32'h0BBB);
        checkValue("noSkidSwap.occupancy", 32'(curOcc), 32'd1);

        // Random run against the model, skid build then single-entry build.
        for (int m = 1; m >= 0; m--) begin
            selOne    = (m == 1);
            modelSkid = (m == 1);
            applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            modelReset();
            @(posedge clk);
            #1;
            runRandom(400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
